div_issue_ctrl: RTL
===================

# div_issue_ctrl

Initiator side of the divider's valid/ready protocol. It sits between the execute-stage M-extension request path and the `div` engine, and accepts signed 32-bit quotient requests. Operand cases the engine cannot handle or would loop on (b = 0, b = ±1, b = INT_MIN) are answered directly. INT_MIN dividends are rewritten so their magnitude fits the engine's 31-bit datapath, and the engine's result is corrected afterwards. All other requests go to the engine unchanged, and the block returns exactly one response per accepted request.

## Interface
- `TIMEOUT_CYCLES`, default 0: maximum cycles in WAIT before the block gives up; 0 disables the timeout.
- `clock` in 1: single clock, rising edge.
- `nreset` in 1: asynchronous, active-low reset.
- `req_valid_i` in 1: upstream request valid.
- `req_ready_o` out 1: block can accept a request; high only in IDLE.
- `req_a_i` in 32: signed dividend.
- `req_b_i` in 32: signed divisor.
- `rsp_valid_o` out 1: response valid; high only in RESP.
- `rsp_ready_i` in 1: upstream accepts the response.
- `rsp_q_o` out 32: signed quotient, truncated toward zero, RISC-V DIV semantics.
- `rsp_timeout_o` out 1: qualifies `rsp_valid_o`; 1 means the engine timed out and `rsp_q_o` = 0.
- `div_in_valid_o` out 1: operand valid to the engine.
- `div_in_ready_i` in 1: engine ready for operands.
- `div_a_o` out 32: dividend to the engine.
- `div_b_o` out 32: divisor to the engine.
- `div_c_i` in 32: engine quotient.
- `div_out_valid_i` in 1: engine result valid.
- `div_out_ready_o` out 1: block accepts the engine result.

## Operation
- States are IDLE, ISSUE, WAIT, RESP and DRAIN. Reset enters IDLE with every output 0 and all registers cleared.
- **IDLE**
  - Request handshake: `req_valid_i & req_ready_o`. On handshake, latch a and b and classify them; INT_MIN = 0x8000_0000.
  - b = 0: q = 0xFFFF_FFFF; go to RESP.
  - b = 1: q = a; go to RESP.
  - b = −1: q = −a mod 2^32, so INT_MIN returns INT_MIN; go to RESP.
  - b = INT_MIN: q = (a == INT_MIN) ? 1 : 0; go to RESP.
  - a = INT_MIN and b > 0: issue a' = INT_MIN + b; adj = −1.
  - a = INT_MIN and b < 0: issue a' = INT_MIN − b; adj = +1.
  - Otherwise: issue a unchanged; adj = 0.
  - Every issue case goes to ISSUE.
- **ISSUE**
  - `div_in_valid_o` = 1 with `div_a_o` and `div_b_o` registered.
  - When `div_in_ready_i` is high, go to WAIT.
- **WAIT**
  - `div_in_valid_o` = 0 and `div_out_ready_o` = 1.
  - When `div_out_valid_i` is high, rsp_q = `div_c_i` + adj (mod 2^32); go to RESP.
  - If `TIMEOUT_CYCLES` ≠ 0 and the wait counter reaches `TIMEOUT_CYCLES`: rsp_q = 0 and `rsp_timeout_o` = 1; go to RESP, with a sticky drain flag set.
- **RESP**
  - `rsp_valid_o` = 1; `rsp_q_o` and `rsp_timeout_o` are held stable until `rsp_ready_i`.
  - On `rsp_ready_i`, go to DRAIN if the drain flag is set, otherwise IDLE.
- **DRAIN**
  - `div_out_ready_o` = 1 and `req_ready_o` = 0.
  - The first `div_out_valid_i` is discarded, the drain flag is cleared, and the block goes to IDLE.
- Exactly one engine transaction is outstanding at any time. `div_in_valid_o` is never high in the same cycle as `div_out_ready_o`.

## Timing
- Bypass latency: accept in cycle N, `rsp_valid_o` in cycle N+1. No engine activity in any cycle.
- Issue path timing:
  - Accept in cycle N; `div_in_valid_o` in cycle N+1.
  - The engine latches operands one cycle after its handshake.
  - Engine result in cycle M; `rsp_valid_o` in cycle M+1.
- `div_a_o` and `div_b_o` stay constant from ISSUE entry until the block returns to IDLE, because the engine samples them one cycle after the handshake.
- The wait counter is 32 bits. It clears on WAIT entry and increments once per WAIT cycle.
- Backpressure: `rsp_valid_o` stays high and the data stays stable for any number of `rsp_ready_i`-low cycles.
- Reset asserted in any state: all outputs return to 0 asynchronously and the state returns to IDLE. The engine is reset by the same `nreset`.

## Structure
- Package `div_pkg`:
  - state enum `div_ctrl_state_e`
  - constant `DIV_INT_MIN`
  - enum `div_case_e`: ZERO, ONE, NEG_ONE, B_MIN, A_MIN_POS, A_MIN_NEG, NORMAL
- Sub-module `div_special_case`: purely combinational. It maps (a, b) to the case kind, the bypass quotient, the issued dividend and adj.

## Test plan
- 100 / 7: issues a = 100, b = 7 → `rsp_q_o` = 14 with `rsp_timeout_o` = 0. −100 / 7 → 0xFFFF_FFF2 (−14).
- 7 / 0: accept in cycle N → `rsp_valid_o` in cycle N+1 with q = 0xFFFF_FFFF. `div_in_valid_o` never asserts.
- INT_MIN / −1 → bypass, q = 0x8000_0000. 5 / INT_MIN → bypass, q = 0.
- INT_MIN / 3: issues `div_a_o` = 0x8000_0003, `div_b_o` = 3; the engine returns 0xD555_5557 → `rsp_q_o` = 0xD555_5556 (−715827882).
- `TIMEOUT_CYCLES` = 16 with a stub engine that never responds:
  - `rsp_valid_o` with `rsp_timeout_o` = 1 and q = 0 after 16 WAIT cycles.
  - `req_ready_o` stays 0 until the stub pulses `div_out_valid_i`.
- Hold `rsp_ready_i` low for 5 cycles: q stays stable and `req_ready_o` = 0. Asserting `nreset` low during WAIT → every output is 0 immediately and the block is in IDLE after release.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue controller.
package div_pkg;

    localparam int unsigned DIV_W = 32;
    localparam logic [DIV_W-1:0] DIV_INT_MIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        DRAIN
    } div_ctrl_state_e;

    typedef enum logic [2:0] {
        ZERO,
        ONE,
        NEG_ONE,
        B_MIN,
        A_MIN_POS,
        A_MIN_NEG,
        NORMAL
    } div_case_e;

    // Cases answered locally without touching the engine.
    function automatic logic div_is_bypass(div_case_e kind);
        return (kind == ZERO) || (kind == ONE) || (kind == NEG_ONE) || (kind == B_MIN);
    endfunction

endpackage

// File: rtl/div_special_case.sv
// Classifies a signed divide request and precomputes bypass / issue operands.
module div_special_case
    import div_pkg::*;
(
    input  logic [DIV_W-1:0] i_a,
    input  logic [DIV_W-1:0] i_b,
    output div_case_e        o_kind,
    output logic [DIV_W-1:0] o_bypass_q,
    output logic [DIV_W-1:0] o_issue_a,
    output logic [DIV_W-1:0] o_adj
);

    // INT_MIN dividends are pulled one divisor toward zero so the magnitude fits 31 bits.
    always_comb begin
        o_kind     = NORMAL;
        o_bypass_q = '0;
        o_issue_a  = i_a;
        o_adj      = '0;
        if (i_b == '0) begin
            o_kind     = ZERO;
            o_bypass_q = '1;
        end else if (i_b == DIV_W'(1)) begin
            o_kind     = ONE;
            o_bypass_q = i_a;
        end else if (i_b == '1) begin
            o_kind     = NEG_ONE;
            o_bypass_q = '0 - i_a;
        end else if (i_b == DIV_INT_MIN) begin
            o_kind     = B_MIN;
            o_bypass_q = (i_a == DIV_INT_MIN) ? DIV_W'(1) : '0;
        end else if ((i_a == DIV_INT_MIN) && !i_b[DIV_W-1]) begin
            o_kind    = A_MIN_POS;
            o_issue_a = i_a + i_b;
            o_adj     = '1;
        end else if (i_a == DIV_INT_MIN) begin
            o_kind    = A_MIN_NEG;
            o_issue_a = i_a - i_b;
            o_adj     = DIV_W'(1);
        end
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Valid/ready initiator in front of the divider engine with special-case bypass and timeout.
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [DIV_W-1:0] req_a_i,
    input  logic [DIV_W-1:0] req_b_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [DIV_W-1:0] rsp_q_o,
    output logic             rsp_timeout_o,
    output logic             div_in_valid_o,
    input  logic             div_in_ready_i,
    output logic [DIV_W-1:0] div_a_o,
    output logic [DIV_W-1:0] div_b_o,
    input  logic [DIV_W-1:0] div_c_i,
    input  logic             div_out_valid_i,
    output logic             div_out_ready_o
);

    localparam logic [DIV_W-1:0] TO_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : DIV_W'(TIMEOUT_CYCLES - 1);

    div_ctrl_state_e  r_state;
    logic             r_req_ready;
    logic             r_rsp_valid;
    logic [DIV_W-1:0] r_rsp_q;
    logic             r_rsp_timeout;
    logic             r_div_in_valid;
    logic             r_div_out_ready;
    logic [DIV_W-1:0] r_div_a;
    logic [DIV_W-1:0] r_div_b;
    logic [DIV_W-1:0] r_adj;
    logic [DIV_W-1:0] r_wait_cnt;
    logic             r_drain;

    div_case_e        w_kind;
    logic [DIV_W-1:0] w_bypass_q;
    logic [DIV_W-1:0] w_issue_a;
    logic [DIV_W-1:0] w_adj;

    div_special_case u_special (
        .i_a        (req_a_i),
        .i_b        (req_b_i),
        .o_kind     (w_kind),
        .o_bypass_q (w_bypass_q),
        .o_issue_a  (w_issue_a),
        .o_adj      (w_adj)
    );

    // Controller FSM; every output is a register updated on the transition into its state.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state         <= IDLE;
            r_req_ready     <= 1'b0;
            r_rsp_valid     <= 1'b0;
            r_rsp_q         <= '0;
            r_rsp_timeout   <= 1'b0;
            r_div_in_valid  <= 1'b0;
            r_div_out_ready <= 1'b0;
            r_div_a         <= '0;
            r_div_b         <= '0;
            r_adj           <= '0;
            r_wait_cnt      <= '0;
            r_drain         <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_req_ready <= 1'b1;
                    if (req_valid_i && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        if (div_is_bypass(w_kind)) begin
                            r_rsp_q       <= w_bypass_q;
                            r_rsp_timeout <= 1'b0;
                            r_rsp_valid   <= 1'b1;
                            r_state       <= RESP;
                        end else begin
                            r_div_a        <= w_issue_a;
                            r_div_b        <= req_b_i;
                            r_adj          <= w_adj;
                            r_div_in_valid <= 1'b1;
                            r_state        <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (div_in_ready_i) begin
                        r_div_in_valid  <= 1'b0;
                        r_div_out_ready <= 1'b1;
                        r_wait_cnt      <= '0;
                        r_state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (div_out_valid_i) begin
                        r_div_out_ready <= 1'b0;
                        r_rsp_q         <= div_c_i + r_adj;
                        r_rsp_timeout   <= 1'b0;
                        r_rsp_valid     <= 1'b1;
                        r_state         <= RESP;
                    end else if ((TIMEOUT_CYCLES != 0) && (r_wait_cnt == TO_LAST)) begin
                        // Engine still owes a result; remember to swallow it later.
                        r_div_out_ready <= 1'b0;
                        r_rsp_q         <= '0;
                        r_rsp_timeout   <= 1'b1;
                        r_rsp_valid     <= 1'b1;
                        r_drain         <= 1'b1;
                        r_state         <= RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + DIV_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        if (r_drain) begin
                            r_div_out_ready <= 1'b1;
                            r_state         <= DRAIN;
                        end else begin
                            r_req_ready <= 1'b1;
                            r_state     <= IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (div_out_valid_i) begin
                        r_div_out_ready <= 1'b0;
                        r_drain         <= 1'b0;
                        r_req_ready     <= 1'b1;
                        r_state         <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o     = r_req_ready;
    assign rsp_valid_o     = r_rsp_valid;
    assign rsp_q_o         = r_rsp_q;
    assign rsp_timeout_o   = r_rsp_timeout;
    assign div_in_valid_o  = r_div_in_valid;
    assign div_out_ready_o = r_div_out_ready;
    assign div_a_o         = r_div_a;
    assign div_b_o         = r_div_b;

endmodule
